// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined CLA adder.
// Exports OP encodings, clog2() and the latency function lat().
package cla_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBB = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Prestage rank plus one rank per LPS prefix levels (last one is the output).
    function automatic int lat(input int n, input int lps);
        return 1 + (clog2(n) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/cla_prefix_lvl.sv
// cla_prefix_lvl: one combinational Kogge-Stone prefix level at distance DIST.
// Ports: PIN/GIN group propagate/generate in, POUT/GOUT combined out.
module cla_prefix_lvl #(
    parameter int N    = 8,
    parameter int DIST = 1
) (
    input  logic [N-1:0] PIN,
    input  logic [N-1:0] GIN,
    output logic [N-1:0] POUT,
    output logic [N-1:0] GOUT
);

    always_comb begin
        POUT = PIN;
        GOUT = GIN;
        for (int i = DIST; i < N; i++) begin
            GOUT[i] = GIN[i] | (PIN[i] & GIN[i-DIST]);
            POUT[i] = PIN[i] & PIN[i-DIST];
        end
    end

endmodule

// File: rtl/cla_pipe_n.sv
// cla_pipe_n: pipelined N-bit Kogge-Stone adder/subtractor with flags,
// tag, valid/ready handshake and in-flight counter.
// Ports: PHI/RST clock+async reset; IN_VLD/IN_RDY, OPA, OPB, CIN, OP, TAG_IN
// in; OUT_VLD/OUT_RDY, SUM, COUT, OVF, ZERO, TAG_OUT out; OCC occupancy.
module cla_pipe_n
    import cla_pkg::*;
#(
    parameter int N   = 32,
    parameter int LPS = 2,
    parameter int TW  = 4
) (
    input  logic                              PHI,
    input  logic                              RST,
    input  logic                              IN_VLD,
    output logic                              IN_RDY,
    input  logic [N-1:0]                      OPA,
    input  logic [N-1:0]                      OPB,
    input  logic                              CIN,
    input  logic [1:0]                        OP,
    input  logic [TW-1:0]                     TAG_IN,
    output logic                              OUT_VLD,
    input  logic                              OUT_RDY,
    output logic [N-1:0]                      SUM,
    output logic                              COUT,
    output logic                              OVF,
    output logic                              ZERO,
    output logic [TW-1:0]                     TAG_OUT,
    output logic [clog2(lat(N, LPS)+1)-1:0]   OCC
);

    localparam int L   = clog2(N);
    localparam int LAT = lat(N, LPS);
    localparam int R   = LAT - 1;
    localparam int OW  = clog2(LAT + 1);

    logic          w_adv;
    logic          w_acc;
    logic          w_pop;
    logic          w_pre_c;
    logic [N-1:0]  w_b;
    logic [N-1:0]  w_pre_p;
    logic [N-1:0]  w_pre_g;
    logic [N-1:0]  w_pre_x;

    logic [N-1:0]  r_p [R];
    logic [N-1:0]  r_g [R];
    logic [N-1:0]  r_x [R];
    logic [TW-1:0] r_t [R];
    logic [R-1:0]  r_c0;
    logic [R-1:0]  r_v;

    logic [N-1:0]  w_pn [R];
    logic [N-1:0]  w_gn [R];
    logic [N-1:0]  w_pi [L];
    logic [N-1:0]  w_gi [L];
    logic [N-1:0]  w_po [L];
    logic [N-1:0]  w_go [L];

    logic [N-1:0]  w_gf;
    logic [N-1:0]  w_carry;
    logic [N-1:0]  w_sum;
    logic          w_unused;

    logic          r_ovld;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_zero;
    logic [TW-1:0] r_tag;
    logic [OW-1:0] r_occ;

    // Subtract is A + ~B + carry; the carry-in is folded into G[0]
    // so the prefix tree output G[i] is directly the carry out of bit i.
    always_comb begin
        case (OP)
            OP_ADD:  w_pre_c = 1'b0;
            OP_SUB:  w_pre_c = 1'b1;
            default: w_pre_c = CIN;
        endcase
        w_b        = OP[1] ? ~OPB : OPB;
        w_pre_p    = OPA | w_b;
        w_pre_g    = OPA & w_b;
        w_pre_g[0] = w_pre_g[0] | (w_pre_p[0] & w_pre_c);
        w_pre_x    = OPA ^ w_b;
    end

    assign w_pn[0] = w_pre_p;
    assign w_gn[0] = w_pre_g;

    // A register rank sits in front of every LPS-th prefix level.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        if (k % LPS == 0) begin : g_rank
            assign w_pi[k] = r_p[k/LPS];
            assign w_gi[k] = r_g[k/LPS];
            if (k > 0) begin : g_next
                assign w_pn[k/LPS] = w_po[k-1];
                assign w_gn[k/LPS] = w_go[k-1];
            end
        end else begin : g_comb
            assign w_pi[k] = w_po[k-1];
            assign w_gi[k] = w_go[k-1];
        end
        cla_prefix_lvl #(
            .N    (N),
            .DIST (1 << k)
        ) u_lvl (
            .PIN  (w_pi[k]),
            .GIN  (w_gi[k]),
            .POUT (w_po[k]),
            .GOUT (w_go[k])
        );
    end

    assign w_gf     = w_go[L-1];
    assign w_carry  = {w_gf[N-2:0], r_c0[R-1]};
    assign w_sum    = r_x[R-1] ^ w_carry;
    assign w_unused = ^w_po[L-1];

    assign w_adv = ~r_ovld | OUT_RDY;
    assign w_acc = IN_VLD & w_adv;
    assign w_pop = r_ovld & OUT_RDY;

    always_ff @(posedge PHI) begin
        if (w_adv) begin
            for (int j = 0; j < R; j++) begin
                r_p[j] <= w_pn[j];
                r_g[j] <= w_gn[j];
            end
            r_x[0]  <= w_pre_x;
            r_c0[0] <= w_pre_c;
            r_t[0]  <= TAG_IN;
            for (int j = 1; j < R; j++) begin
                r_x[j]  <= r_x[j-1];
                r_c0[j] <= r_c0[j-1];
                r_t[j]  <= r_t[j-1];
            end
        end
    end

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            r_v    <= '0;
            r_ovld <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_tag  <= '0;
            r_occ  <= '0;
        end else begin
            if (w_adv) begin
                r_v[0] <= w_acc;
                for (int j = 1; j < R; j++) begin
                    r_v[j] <= r_v[j-1];
                end
                r_ovld <= r_v[R-1];
                r_sum  <= w_sum;
                r_cout <= w_gf[N-1];
                r_ovf  <= w_gf[N-1] ^ w_gf[N-2];
                r_zero <= ~|w_sum;
                r_tag  <= r_t[R-1];
            end
            if (w_acc && !w_pop) begin
                r_occ <= r_occ + OW'(1);
            end else if (!w_acc && w_pop) begin
                r_occ <= r_occ - OW'(1);
            end
        end
    end

    assign IN_RDY  = w_adv;
    assign OUT_VLD = r_ovld;
    assign SUM     = r_sum;
    assign COUT    = r_cout;
    assign OVF     = r_ovf;
    assign ZERO    = r_zero;
    assign TAG_OUT = r_tag;
    assign OCC     = r_occ;

endmodule

// File: tb/tb_cla_pipe_n.sv
// tb_cla_pipe_n: self-checking bench for cla_pipe_n (N=8/LPS=1 and N=32/LPS=5).
// Directed vector table, backpressure, mid-stream reset and random scoreboard.
module tb_cla_pipe_n;
    import cla_pkg::*;

    localparam int OW1 = clog2(lat(8, 1) + 1);
    localparam int OW2 = clog2(lat(32, 5) + 1);
    localparam int TGT = 1500;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        res_t       r;
        logic [3:0] tag;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       cin;
        logic [3:0] tag;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
        logic       ezero;
    } vec_t;

    logic PHI = 1'b0;
    logic RST = 1'b0;

    logic           IN_VLD = 1'b0;
    logic           IN_RDY;
    logic [7:0]     OPA = '0;
    logic [7:0]     OPB = '0;
    logic           CIN = 1'b0;
    logic [1:0]     OP = '0;
    logic [3:0]     TAG_IN = '0;
    logic           OUT_VLD;
    logic           OUT_RDY = 1'b1;
    logic [7:0]     SUM;
    logic           COUT;
    logic           OVF;
    logic           ZERO;
    logic [3:0]     TAG_OUT;
    logic [OW1-1:0] OCC;

    logic           b_in_vld = 1'b0;
    logic           b_in_rdy;
    logic [31:0]    b_opa = '0;
    logic [31:0]    b_opb = '0;
    logic           b_cin = 1'b0;
    logic [1:0]     b_op = '0;
    logic [3:0]     b_tag_in = '0;
    logic           b_out_vld;
    logic           b_out_rdy = 1'b1;
    logic [31:0]    b_sum;
    logic           b_cout;
    logic           b_ovf;
    logic           b_zero;
    logic [3:0]     b_tag_out;
    logic [OW2-1:0] b_occ;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc1 = 0;
    int   n_acc2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 PHI = ~PHI;

    cla_pipe_n #(.N(8), .LPS(1), .TW(4)) u_dut (
        .PHI(PHI), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .OP(OP), .TAG_IN(TAG_IN),
        .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .SUM(SUM), .COUT(COUT),
        .OVF(OVF), .ZERO(ZERO), .TAG_OUT(TAG_OUT), .OCC(OCC)
    );

    cla_pipe_n #(.N(32), .LPS(5), .TW(4)) u_dut32 (
        .PHI(PHI), .RST(RST), .IN_VLD(b_in_vld), .IN_RDY(b_in_rdy),
        .OPA(b_opa), .OPB(b_opb), .CIN(b_cin), .OP(b_op), .TAG_IN(b_tag_in),
        .OUT_VLD(b_out_vld), .OUT_RDY(b_out_rdy), .SUM(b_sum), .COUT(b_cout),
        .OVF(b_ovf), .ZERO(b_zero), .TAG_OUT(b_tag_out), .OCC(b_occ)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic cin);
        res_t        r;
        logic [32:0] s;
        logic [31:0] bb;
        logic [31:0] mask;
        logic        c;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bb     = (op[1] ? ~b : b) & mask;
        c      = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
        s      = {1'b0, a & mask} + {1'b0, bb} + {32'd0, c};
        r.sum  = s[31:0] & mask;
        r.cout = s[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    always @(negedge PHI) begin
        if (!RST) begin
            chk("sb1_occ", 32'(OCC), 32'(q1.size()));
            if (OUT_VLD && OUT_RDY) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb1_underflow: unexpected output tag %0h", TAG_OUT);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("sb1_sum", 32'(SUM), e.r.sum);
                    chk("sb1_cout", 32'(COUT), 32'(e.r.cout));
                    chk("sb1_ovf", 32'(OVF), 32'(e.r.ovf));
                    chk("sb1_zero", 32'(ZERO), 32'(e.r.zero));
                    chk("sb1_tag", 32'(TAG_OUT), 32'(e.tag));
                end
            end
            if (IN_VLD && IN_RDY) begin
                q1.push_back({model(8, 32'(OPA), 32'(OPB), OP, CIN), TAG_IN});
                n_acc1++;
            end
        end
    end

    always @(negedge PHI) begin
        if (!RST) begin
            chk("sb2_occ", 32'(b_occ), 32'(q2.size()));
            if (b_out_vld && b_out_rdy) begin
                if (q2.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb2_underflow: unexpected output tag %0h", b_tag_out);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("sb2_sum", b_sum, e.r.sum);
                    chk("sb2_cout", 32'(b_cout), 32'(e.r.cout));
                    chk("sb2_ovf", 32'(b_ovf), 32'(e.r.ovf));
                    chk("sb2_zero", 32'(b_zero), 32'(e.r.zero));
                    chk("sb2_tag", 32'(b_tag_out), 32'(e.tag));
                end
            end
            if (b_in_vld && b_in_rdy) begin
                q2.push_back({model(32, b_opa, b_opb, b_op, b_cin), b_tag_in});
                n_acc2++;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic cin, input logic [3:0] tag);
        int n;
        n = 0;
        OPA = a; OPB = b; OP = op; CIN = cin; TAG_IN = tag; IN_VLD = 1'b1;
        do begin
            @(negedge PHI);
            n++;
        end while (!IN_RDY && n < 50);
        chk("send_in_rdy", 32'(IN_RDY), 32'd1);
        @(posedge PHI);
        #1;
        IN_VLD = 1'b0;
    endtask

    task automatic wait_out(output int lat_o);
        lat_o = 0;
        do begin
            @(negedge PHI);
            lat_o++;
        end while (!OUT_VLD && lat_o < 20);
    endtask

    vec_t    vt[8];
    int      lt;
    int      pend;
    int      nv;
    logic [3:0] got[$];

    initial begin
        vt[0] = '{8'hFF, 8'h01, 2'b00, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[1] = '{8'hFF, 8'h01, 2'b01, 1'b1, 4'h5, 8'h01, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 2'b00, 1'b0, 4'h6, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h05, 8'h07, 2'b10, 1'b0, 4'h7, 8'hFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 2'b10, 1'b0, 4'h8, 8'h7F, 1'b1, 1'b1, 1'b0};
        vt[5] = '{8'h05, 8'h05, 2'b11, 1'b0, 4'h9, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[6] = '{8'h05, 8'h05, 2'b10, 1'b1, 4'hA, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[7] = '{8'h80, 8'h80, 2'b00, 1'b1, 4'hB, 8'h00, 1'b1, 1'b1, 1'b1};

        #1 RST = 1'b1;
        #12;
        chk("por_out_vld", 32'(OUT_VLD), 32'd0);
        chk("por_occ", 32'(OCC), 32'd0);
        chk("por_sum", 32'(SUM), 32'd0);
        chk("por_tag", 32'(TAG_OUT), 32'd0);
        chk("por_out_vld32", 32'(b_out_vld), 32'd0);
        @(posedge PHI);
        #3 RST = 1'b0;
        @(negedge PHI);
        chk("por_in_rdy", 32'(IN_RDY), 32'd1);
        @(posedge PHI);
        #1;

        for (int i = 0; i < 8; i++) begin
            send(vt[i].a, vt[i].b, vt[i].op, vt[i].cin, vt[i].tag);
            wait_out(lt);
            chk("dir_latency", 32'(lt), 32'd4);
            chk("dir_vld", 32'(OUT_VLD), 32'd1);
            chk("dir_sum", 32'(SUM), 32'(vt[i].esum));
            chk("dir_cout", 32'(COUT), 32'(vt[i].ecout));
            chk("dir_ovf", 32'(OVF), 32'(vt[i].eovf));
            chk("dir_zero", 32'(ZERO), 32'(vt[i].ezero));
            chk("dir_tag", 32'(TAG_OUT), 32'(vt[i].tag));
            @(posedge PHI);
            #1;
        end

        pend = 0;
        got.delete();
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            OUT_RDY = !(cyc >= 4 && cyc < 7);
            if (pend < 6) begin
                OPA = 8'(pend * 17 + 3);
                OPB = 8'(pend * 5);
                OP = 2'b00;
                CIN = 1'b0;
                TAG_IN = 4'(pend);
                IN_VLD = 1'b1;
            end else begin
                IN_VLD = 1'b0;
            end
            @(negedge PHI);
            if (cyc >= 4 && cyc < 7) begin
                chk("bp_in_rdy", 32'(IN_RDY), 32'd0);
                chk("bp_occ", 32'(OCC), 32'd4);
                chk("bp_out_vld", 32'(OUT_VLD), 32'd1);
                chk("bp_hold_tag", 32'(TAG_OUT), 32'd0);
                chk("bp_hold_sum", 32'(SUM), 32'h03);
            end
            if (OUT_VLD && OUT_RDY) got.push_back(TAG_OUT);
            if (IN_VLD && IN_RDY) pend++;
            @(posedge PHI);
            #1;
        end
        IN_VLD = 1'b0;
        OUT_RDY = 1'b1;
        chk("bp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++) begin
            chk("bp_order", 32'(got[i]), 32'(i));
        end

        OUT_RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OPA = 8'(8'h10 + i);
            OPB = 8'h21;
            OP = 2'b00;
            CIN = 1'b0;
            TAG_IN = 4'(7 + i);
            IN_VLD = 1'b1;
            @(posedge PHI);
            #1;
        end
        IN_VLD = 1'b0;
        @(negedge PHI);
        chk("pre_rst_vld", 32'(OUT_VLD), 32'd1);
        chk("pre_rst_occ", 32'(OCC), 32'd4);
        chk("pre_rst_tag", 32'(TAG_OUT), 32'd7);
        chk("pre_rst_sum", 32'(SUM), 32'h31);
        #2;
        RST = 1'b1;
        q1.delete();
        q2.delete();
        #1;
        chk("rst_out_vld", 32'(OUT_VLD), 32'd0);
        chk("rst_occ", 32'(OCC), 32'd0);
        chk("rst_sum", 32'(SUM), 32'd0);
        chk("rst_cout", 32'(COUT), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_zero", 32'(ZERO), 32'd0);
        chk("rst_tag", 32'(TAG_OUT), 32'd0);
        OUT_RDY = 1'b1;
        @(posedge PHI);
        #3 RST = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge PHI);
            if (c == 0) chk("rst_in_rdy", 32'(IN_RDY), 32'd1);
            if (OUT_VLD) nv++;
        end
        chk("rst_no_ghost", 32'(nv), 32'd0);
        @(posedge PHI);
        #1;

        n_acc1 = 0;
        n_acc2 = 0;
        for (int cyc = 0; cyc < 20000 && (n_acc1 < TGT || n_acc2 < TGT); cyc++) begin
            IN_VLD = ($urandom_range(0, 9) < 7) && (n_acc1 < TGT);
            OPA = 8'($urandom);
            OPB = 8'($urandom);
            OP = 2'($urandom_range(0, 3));
            CIN = 1'($urandom_range(0, 1));
            TAG_IN = 4'($urandom);
            OUT_RDY = ($urandom_range(0, 9) < 6);
            b_in_vld = ($urandom_range(0, 9) < 7) && (n_acc2 < TGT);
            b_opa = $urandom;
            b_opb = $urandom;
            b_op = 2'($urandom_range(0, 3));
            b_cin = 1'($urandom_range(0, 1));
            b_tag_in = 4'($urandom);
            b_out_rdy = ($urandom_range(0, 9) < 6);
            @(posedge PHI);
            #1;
        end
        IN_VLD = 1'b0;
        b_in_vld = 1'b0;
        OUT_RDY = 1'b1;
        b_out_rdy = 1'b1;
        for (int c = 0; c < 50 && (q1.size() != 0 || q2.size() != 0); c++) begin
            @(posedge PHI);
            #1;
        end
        @(negedge PHI);
        chk("rnd_acc1", 32'(n_acc1), 32'(TGT));
        chk("rnd_acc2", 32'(n_acc2), 32'(TGT));
        chk("rnd_drain1", 32'(q1.size()), 32'd0);
        chk("rnd_drain2", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
